// File: rtl/rope_pkg.sv
// Shared definitions for the rope tug-of-war game: FSM states, winner codes
// and the default rope geometry used by both the controller and the renderer.
package rope_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAY      = 2'd2,
        ST_WIN       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_LEFT  = 2'b01,
        WIN_RIGHT = 2'b10
    } winner_t;

    localparam logic [9:0] CENTER_DEF  = 10'd320;
    localparam logic [9:0] LIMIT_L_DEF = 10'd64;
    localparam logic [9:0] LIMIT_R_DEF = 10'd576;

endpackage

// File: rtl/rope_game_ctrl_if.sv
// Player/frame inputs and rope/status outputs of the game controller.
// The controller uses the slave view; whatever drives the buttons uses master.
interface rope_game_ctrl_if;

    logic       i_start;
    logic       i_pull_l;
    logic       i_pull_r;
    logic       i_frame;
    logic [9:0] rope_loc;
    logic [1:0] o_state;
    logic [1:0] o_winner;
    logic [7:0] o_cd_frame;

    modport master (
        output i_start, i_pull_l, i_pull_r, i_frame,
        input  rope_loc, o_state, o_winner, o_cd_frame
    );

    modport slave (
        input  i_start, i_pull_l, i_pull_r, i_frame,
        output rope_loc, o_state, o_winner, o_cd_frame
    );

endinterface

// File: rtl/rope_edge_det.sv
// Registered rising-edge detector: pulse is high for one cycle, the cycle
// after level is first seen high.
module rope_edge_det (
    input  logic clk,
    input  logic rstn,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/rope_game_ctrl.sv
// Tug-of-war game controller: start/countdown, per-frame rope movement from
// the net button-pull difference, win detection and win display hold.
module rope_game_ctrl
    import rope_pkg::*;
#(
    parameter logic [9:0] CENTER     = CENTER_DEF,
    parameter logic [9:0] LIMIT_L    = LIMIT_L_DEF,
    parameter logic [9:0] LIMIT_R    = LIMIT_R_DEF,
    parameter int         STEP       = 4,
    parameter int         CD_FRAMES  = 180,
    parameter int         WIN_FRAMES = 120
) (
    input logic              clk,
    input logic              rstn,
    rope_game_ctrl_if.slave  bus
);

    state_t            state, state_n;
    winner_t           winner, winner_n;
    logic [9:0]        rope, rope_n;
    logic [7:0]        cd_cnt, cd_n;
    logic [7:0]        win_cnt, win_n;
    logic [3:0]        cnt_l, cnt_l_n;
    logic [3:0]        cnt_r, cnt_r_n;
    logic              start_e, pull_l_e, pull_r_e;
    logic signed [11:0] delta, next_pos;

    rope_edge_det u_start_det (.clk(clk), .rstn(rstn), .level(bus.i_start),  .pulse(start_e));
    rope_edge_det u_pull_l_det(.clk(clk), .rstn(rstn), .level(bus.i_pull_l), .pulse(pull_l_e));
    rope_edge_det u_pull_r_det(.clk(clk), .rstn(rstn), .level(bus.i_pull_r), .pulse(pull_r_e));

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n  = state;
        winner_n = winner;
        rope_n   = rope;
        cd_n     = cd_cnt;
        win_n    = win_cnt;
        cnt_l_n  = cnt_l;
        cnt_r_n  = cnt_r;
        delta    = ($signed({8'd0, cnt_r}) - $signed({8'd0, cnt_l})) * 12'(STEP);
        next_pos = $signed({2'b00, rope}) + delta;

        case (state)
            ST_IDLE: begin
                rope_n   = CENTER;
                winner_n = WIN_NONE;
                cnt_l_n  = 4'd0;
                cnt_r_n  = 4'd0;
                cd_n     = 8'd0;
                if (start_e) begin
                    state_n = ST_COUNTDOWN;
                    cd_n    = 8'(CD_FRAMES);
                end
            end
            ST_COUNTDOWN: begin
                if (bus.i_frame) begin
                    if (cd_cnt <= 8'd1) begin
                        state_n = ST_PLAY;
                        cd_n    = 8'd0;
                    end else begin
                        cd_n = cd_cnt - 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (start_e) begin
                    state_n = ST_IDLE;
                    rope_n  = CENTER;
                    cnt_l_n = 4'd0;
                    cnt_r_n = 4'd0;
                end else if (bus.i_frame) begin
                    // An edge landing on the frame tick seeds the next frame's count.
                    cnt_l_n = {3'b000, pull_l_e};
                    cnt_r_n = {3'b000, pull_r_e};
                    if (next_pos <= $signed({2'b00, LIMIT_L})) begin
                        rope_n   = LIMIT_L;
                        winner_n = WIN_LEFT;
                        state_n  = ST_WIN;
                    end else if (next_pos >= $signed({2'b00, LIMIT_R})) begin
                        rope_n   = LIMIT_R;
                        winner_n = WIN_RIGHT;
                        state_n  = ST_WIN;
                    end else begin
                        rope_n = next_pos[9:0];
                    end
                    if (state_n == ST_WIN) begin
                        win_n   = 8'(WIN_FRAMES);
                        cnt_l_n = 4'd0;
                        cnt_r_n = 4'd0;
                    end
                end else begin
                    if (pull_l_e && cnt_l != 4'd15) cnt_l_n = cnt_l + 4'd1;
                    if (pull_r_e && cnt_r != 4'd15) cnt_r_n = cnt_r + 4'd1;
                end
            end
            ST_WIN: begin
                if (bus.i_frame) begin
                    if (win_cnt <= 8'd1) begin
                        state_n  = ST_IDLE;
                        rope_n   = CENTER;
                        winner_n = WIN_NONE;
                        win_n    = 8'd0;
                    end else begin
                        win_n = win_cnt - 8'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            winner  <= WIN_NONE;
            rope    <= CENTER;
            cd_cnt  <= 8'd0;
            win_cnt <= 8'd0;
            cnt_l   <= 4'd0;
            cnt_r   <= 4'd0;
        end else begin
            state   <= state_n;
            winner  <= winner_n;
            rope    <= rope_n;
            cd_cnt  <= cd_n;
            win_cnt <= win_n;
            cnt_l   <= cnt_l_n;
            cnt_r   <= cnt_r_n;
        end
    end

    assign bus.rope_loc   = rope;
    assign bus.o_state    = state;
    assign bus.o_winner   = winner;
    assign bus.o_cd_frame = cd_cnt;

endmodule

// File: doc/rope_game_ctrl.md
ROPE_GAME_CTRL -- requirements
Module: rope_game_ctrl

Interface
REQ-001 Parameters SHALL be: CENTER 10'd320 (rope rest column); LIMIT_L 10'd64 (left win column); LIMIT_R 10'd576 (right win column); STEP 4 (pixels per net pull); CD_FRAMES 180 (countdown length in frames); WIN_FRAMES 120 (win display length in frames).
REQ-002 clk  in  1  core clock; the only clock in the block.
REQ-003 rstn  in  1  asynchronous active-low reset.
REQ-004 i_start  in  1  debounced start level, sampled on its rising edge.
REQ-005 i_pull_l / i_pull_r  in  1 each  debounced player button levels, sampled on their rising edges.
REQ-006 i_frame  in  1  single-cycle frame tick, already synchronous to clk.
REQ-007 rope_loc  out  10  registered rope centre column driven to the rope renderer.
REQ-008 o_state  out  2  current FSM state, using the package encoding.
REQ-009 o_winner  out  2  00 none, 01 left, 10 right.
REQ-010 o_cd_frame  out  8  frames remaining in the countdown; 0 outside COUNTDOWN.

Function
REQ-011 Each of i_start, i_pull_l and i_pull_r SHALL be rising-edge detected through one register stage, so an edge pulse occurs the cycle after the input goes high.
REQ-012 The FSM SHALL have four states: IDLE=0, COUNTDOWN=1, PLAY=2, WIN=3.
REQ-013 IDLE SHALL hold rope_loc=CENTER and o_winner=00; a start edge SHALL move to COUNTDOWN on the next cycle and load the countdown counter with CD_FRAMES.
REQ-014 In COUNTDOWN, each i_frame SHALL decrement the counter; the i_frame that takes it from 1 to 0 SHALL enter PLAY. Pull edges in COUNTDOWN SHALL be ignored.
REQ-015 In PLAY, pull edges SHALL increment per-player 4-bit counters cnt_l and cnt_r, each saturating at 15.
REQ-016 On an i_frame in PLAY: compute next = rope_loc + STEP*(cnt_r - cnt_l) as a signed 12-bit value, register it into rope_loc, and clear both counters in the same cycle.
REQ-017 A pull edge that coincides with an i_frame SHALL be counted in the next frame's counter, not lost and not counted twice.
REQ-018 If both players produce pull edges in the same cycle, both counters SHALL increment.
REQ-019 When next <= LIMIT_L: rope_loc=LIMIT_L, o_winner=01, go to WIN. When next >= LIMIT_R: rope_loc=LIMIT_R, o_winner=10, go to WIN. Otherwise stay in PLAY.
REQ-020 WIN SHALL hold rope_loc and o_winner for WIN_FRAMES frames, then go to IDLE. Start edges in WIN SHALL be ignored.
REQ-021 A start edge in PLAY SHALL abort the game: go to IDLE with rope_loc=CENTER and both counters cleared.
REQ-022 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-023 While rstn is low, asynchronously: state=IDLE, rope_loc=CENTER, o_winner=00, o_cd_frame=0, and all counters and edge registers cleared.
REQ-024 Reset asserted mid-game SHALL discard any pending counts; after release the block SHALL wait for a new start edge.
REQ-025 Edge-detect registers SHALL reset to 0, so an input held high through reset release produces an edge one cycle after release.

Structure
REQ-026 Package rope_pkg SHALL hold the state enum typedef, the winner encoding, and the CENTER/LIMIT defaults, shared with the rope renderer.
REQ-027 One sub-module, rope_edge_det (registered rising-edge detector), SHALL be instantiated three times.
REQ-028 Target implementation size: 150-250 lines RTL.

Verification
REQ-029 Reset, then a start edge, then 180 i_frame pulses -> o_state goes IDLE->COUNTDOWN->PLAY on the 180th frame; rope_loc=320 throughout.
REQ-030 In PLAY, 3 right pulls and 1 left pull, then i_frame -> rope_loc=328 the following cycle and counters read 0.
REQ-031 20 right pulls in one frame -> the counter saturates at 15 and rope_loc increases by 60.
REQ-032 Repeated left pulls until next <= 64 -> rope_loc=64, o_winner=01, state WIN; after 120 frames the state is IDLE with rope_loc=320.
REQ-033 Pull edge coincident with i_frame -> the edge is absent from the current update and present in the next; simultaneous left and right edges -> net 0 change.
REQ-034 rstn pulsed low mid-PLAY with rope_loc=400 -> immediate rope_loc=320 and state IDLE; a start edge is required to resume.
